// File: rtl/flash_resp_pkg.sv
// Shared types and constants for the flash read responder.
package flash_resp_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStall,
      StGrant,
      StLatency,
      StRespond
   } state_e;

   localparam int unsigned WORD_IDX_W = 18;
   localparam int unsigned CNT_W      = 16;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois LFSR step.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/flash_word_ram.sv
// 32-bit word store: one write port, one registered read port, read-before-write on collision.
module flash_word_ram #(
   parameter int unsigned DEPTH = 262144,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_o <= mem[raddr_i];
      end
   end

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read responder serving packed 16-bit samples with modelled flash wait/latency timing.
// Define FLASH_RESP_RANDOM_WAIT_EN to draw each stall length from an LFSR instead of WAIT_CYCLES.
module flash_read_responder
   import flash_resp_pkg::*;
#(
   parameter int unsigned ADDR_W       = 23,
   parameter int unsigned DEPTH_WORDS  = 262144,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter int unsigned READ_LATENCY = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  read,
   input  logic [ADDR_W-1:0]     address,
   output logic                  waitrequest,
   output logic [31:0]           readdata,
   output logic                  readvalid,
   input  logic                  wr_en,
   input  logic [WORD_IDX_W-1:0] wr_addr,
   input  logic [31:0]           wr_data,
   output logic                  addr_err
);

   localparam int unsigned RamAw = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] stall_len;
   logic             wait_q;
   logic             valid_q;
   logic             err_q;
   logic             oor_q;
   logic [31:0]      rdata_q;
   logic [31:0]      ram_rdata;
   logic [31:0]      fetched;
   logic [ADDR_W-2:0] word_idx;
   logic             rd_in_range;
   logic             wr_in_range;
   logic             ram_re;
   logic             ram_we;
   logic             unused_sample_sel;

   // The whole word goes back; picking the half-word is the master's job.
   assign word_idx          = address[ADDR_W-1:1];
   assign unused_sample_sel = address[0];

   assign rd_in_range = 32'(word_idx) < DEPTH_WORDS;
   assign wr_in_range = 32'(wr_addr) < DEPTH_WORDS;
   assign ram_re      = (state_q == StGrant) && read;
   assign ram_we      = wr_en && wr_in_range;

   flash_word_ram #(
      .DEPTH (DEPTH_WORDS),
      .AW    (RamAw)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (wr_addr[RamAw-1:0]),
      .wdata_i (wr_data),
      .re_i    (ram_re),
      .raddr_i (word_idx[RamAw-1:0]),
      .rdata_o (ram_rdata)
   );

`ifdef FLASH_RESP_RANDOM_WAIT_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign stall_len = CNT_W'(32'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));
`else
   assign stall_len = CNT_W'(WAIT_CYCLES);
`endif

   // Out-of-range grants skip the RAM word and return zero.
   assign fetched = oor_q ? 32'h0 : ram_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wait_q  <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         wait_q  <= 1'b1;
         valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (read) begin
                  if (stall_len == '0) begin
                     state_q <= StGrant;
                     wait_q  <= 1'b0;
                  end else begin
                     state_q <= StStall;
                     cnt_q   <= stall_len - CNT_W'(1);
                  end
               end
            end
            StStall: begin
               if (!read) begin
                  state_q <= StIdle;
               end else if (cnt_q == '0) begin
                  state_q <= StGrant;
                  wait_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StGrant: begin
               if (!read) begin
                  state_q <= StIdle;
               end else begin
                  oor_q <= !rd_in_range;
                  if (!rd_in_range) begin
                     err_q <= 1'b1;
                  end
                  if (READ_LATENCY <= 1) begin
                     state_q <= StRespond;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= StLatency;
                     cnt_q   <= CNT_W'(READ_LATENCY - 2);
                  end
               end
            end
            StLatency: begin
               if (cnt_q == '0) begin
                  state_q <= StRespond;
                  valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            StRespond: begin
               state_q <= StIdle;
               rdata_q <= fetched;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign waitrequest = wait_q;
   assign readvalid   = valid_q;
   assign readdata    = (state_q == StRespond) ? fetched : rdata_q;
   assign addr_err    = err_q;

endmodule
